multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencing controller for the NPC core. Steps each instruction through fetch, decode, execute, memory and writeback, and drives the memory request/response handshakes. Issues the one-cycle write strobes for the IR, PC and register file that the single-cycle control path cannot time. Per-instruction datapath selects stay with the combinational decoder; this block only sequences.

## Interface
- WAIT_MAX, 16, maximum cycles a FETCH or MEM wait may last before a bus-error trap; must be ≥1.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  7  opcode field of the current IR.
- ifu_req  out  1  instruction fetch request.
- ifu_rvalid  in  1  fetch response valid; instruction data is on the bus this cycle.
- ir_we  out  1  IR load strobe.
- lsu_req  out  1  data memory request.
- lsu_wen  out  1  qualifies lsu_req as a store.
- lsu_done  in  1  data access complete; load data is valid this cycle.
- reg_we  out  1  register file write strobe.
- pc_we  out  1  PC update strobe.
- halted  out  1  ebreak reached.
- bus_err  out  1  wait timeout trap.
- illegal  out  1  unsupported opcode trap.
- state  out  3  current state, for debug and difftest.
- retire_cnt  out  32  count of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Supported opcode classes:
  - ALU/U/J: 0110111, 0010111, 0010011, 1101111, 1100111.
  - LOAD 0000011; STORE 0100011; EBREAK 1110011.
  - Any other value is illegal.
- IDLE: all strobes 0. Goes to FETCH next cycle.
- FETCH: ifu_req=1.
  - If ifu_rvalid=1: ir_we=1 in the same cycle (Mealy), next state DECODE.
  - Otherwise remain in FETCH.
- DECODE: classifies the opcode, which is now stable.
  - EBREAK → HALT.
  - Illegal → ERR.
  - Otherwise → EXEC.
- EXEC: one cycle for the ALU.
  - LOAD or STORE → MEM.
  - Otherwise → WB.
- MEM: lsu_req=1, and lsu_wen=1 for STORE.
  - If lsu_done=1 → WB.
  - Otherwise remain in MEM.
- WB: pc_we=1.
  - reg_we=1 unless STORE.
  - retire_cnt increments by 1 and wraps 0xFFFFFFFF→0.
  - Next state FETCH.
- Opcode class is latched on entry to EXEC, so IR changes after DECODE do not alter the path.
- HALT: halted=1. All strobes 0. Sticky until rst.
- ERR: all strobes 0. Sticky until rst.
  - bus_err=1 if entered by timeout.
  - illegal=1 if entered from DECODE.
  - The two flags are mutually exclusive.
- Wait counter, width clog2(WAIT_MAX+1):
  - Cleared on entry to FETCH or MEM; increments each cycle spent waiting.
  - If it reaches WAIT_MAX in a cycle where the response is not present → ERR with bus_err=1.
  - A response arriving in that same cycle wins: normal transition, no trap.
- Responses outside their wait state are ignored: ifu_rvalid outside FETCH, lsu_done outside MEM.

## Timing
- Reset: state=IDLE. ifu_req, ir_we, lsu_req, lsu_wen, reg_we, pc_we, halted, bus_err and illegal are all 0. retire_cnt=0. Wait counter=0.
- rst is sampled every cycle and overrides everything, including mid-MEM. lsu_req drops the cycle after rst is sampled, with no completion strobe.
- Zero-wait ALU instruction (ifu_rvalid in the first FETCH cycle): FETCH, DECODE, EXEC, WB = 4 cycles. The next FETCH starts in cycle 5.
- Load or store with lsu_done in the first MEM cycle: 5 cycles. Each extra wait cycle adds 1.
- The first ifu_req after reset deassertion appears in the second cycle (IDLE occupies one cycle).
- ir_we, pc_we and reg_we are each high for exactly one cycle per instruction. pc_we and reg_we are always in the same cycle.

## Test plan
- Reset, then addi with ifu_rvalid in the first FETCH cycle → state sequence 0,1,2,3,5,1. ir_we pulses in the FETCH cycle. reg_we and pc_we pulse together in WB. retire_cnt=1.
- Load with lsu_done after 3 MEM cycles → lsu_req high for 3 cycles, lsu_wen=0, reg_we=1 in WB. Store with the same timing → lsu_wen=1, reg_we=0, pc_we=1.
- ebreak (opcode 1110011) → state 6 and halted=1 from the cycle after DECODE. No pc_we. ifu_rvalid pulses while halted leave the state unchanged.
- Timeout with WAIT_MAX=4:
  - ifu_rvalid held 0 → ERR with bus_err=1 after 4 FETCH cycles.
  - Repeat with ifu_rvalid on the 4th cycle → DECODE, no trap.
- Opcode 0110011 → ERR, illegal=1, bus_err=0, retire_cnt unchanged.
- rst asserted during the 2nd MEM cycle → next cycle all outputs at reset values and state=0. Normal fetch resumes afterward.
- Preload retire_cnt=0xFFFFFFFF via 2^32 retires or a forced state, then retire one instruction → retire_cnt=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with bus-wait watchdog
module multicycle_ctrl #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  output logic        ifu_req,
  input  logic        ifu_rvalid,
  output logic        ir_we,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_done,
  output logic        reg_we,
  output logic        pc_we,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_EBREAK = 7'b1110011;

  // Counter must be able to hold WAIT_MAX itself, since it reaches it on the trap cycle.
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        st;
  logic [CW-1:0] wait_cnt;
  logic          cls_load;
  logic          cls_store;

  logic op_legal;
  logic op_load;
  logic op_store;
  logic op_ebreak;

  assign state = st;

  // ifu_req is registered high exactly while in FETCH, so this gives the
  // same-cycle IR load on the response without a second state decode.
  assign ir_we = ifu_req & ifu_rvalid;

  // Opcode classification; only consulted in DECODE, where the IR is stable.
  always_comb begin
    op_legal  = 1'b0;
    op_load   = 1'b0;
    op_store  = 1'b0;
    op_ebreak = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_ALUI, OP_JAL, OP_JALR: op_legal = 1'b1;
      OP_LOAD: begin
        op_legal = 1'b1;
        op_load  = 1'b1;
      end
      OP_STORE: begin
        op_legal = 1'b1;
        op_store = 1'b1;
      end
      OP_EBREAK: begin
        op_legal  = 1'b1;
        op_ebreak = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Sequencer: state, wait watchdog, retire counter and registered strobes.
  // Strobes are computed for the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      wait_cnt   <= '0;
      cls_load   <= 1'b0;
      cls_store  <= 1'b0;
      ifu_req    <= 1'b0;
      lsu_req    <= 1'b0;
      lsu_wen    <= 1'b0;
      reg_we     <= 1'b0;
      pc_we      <= 1'b0;
      halted     <= 1'b0;
      bus_err    <= 1'b0;
      illegal    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      // One-cycle strobes default low; the trap flags are sticky.
      ifu_req <= 1'b0;
      lsu_req <= 1'b0;
      lsu_wen <= 1'b0;
      reg_we  <= 1'b0;
      pc_we   <= 1'b0;

      case (st)
        ST_IDLE: begin
          st       <= ST_FETCH;
          ifu_req  <= 1'b1;
          wait_cnt <= '0;
        end

        ST_FETCH: begin
          if (ifu_rvalid) begin
            // A response on the last allowed cycle still wins over the trap.
            st <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            st       <= ST_ERR;
            bus_err  <= 1'b1;
            wait_cnt <= wait_cnt + CNT_ONE;
          end else begin
            ifu_req  <= 1'b1;
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        ST_DECODE: begin
          if (op_ebreak) begin
            st     <= ST_HALT;
            halted <= 1'b1;
          end else if (!op_legal) begin
            st      <= ST_ERR;
            illegal <= 1'b1;
          end else begin
            // Latch the class so later IR changes cannot redirect the path.
            st        <= ST_EXEC;
            cls_load  <= op_load;
            cls_store <= op_store;
          end
        end

        ST_EXEC: begin
          if (cls_load || cls_store) begin
            st       <= ST_MEM;
            lsu_req  <= 1'b1;
            lsu_wen  <= cls_store;
            wait_cnt <= '0;
          end else begin
            st     <= ST_WB;
            pc_we  <= 1'b1;
            reg_we <= 1'b1;
          end
        end

        ST_MEM: begin
          if (lsu_done) begin
            st     <= ST_WB;
            pc_we  <= 1'b1;
            reg_we <= !cls_store;
          end else if (wait_cnt == WAIT_LAST) begin
            st       <= ST_ERR;
            bus_err  <= 1'b1;
            wait_cnt <= wait_cnt + CNT_ONE;
          end else begin
            lsu_req  <= 1'b1;
            lsu_wen  <= cls_store;
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end

        ST_WB: begin
          st         <= ST_FETCH;
          ifu_req    <= 1'b1;
          wait_cnt   <= '0;
          retire_cnt <= retire_cnt + 32'd1;
        end

        // HALT and ERR are terminal until reset.
        ST_HALT: st <= ST_HALT;
        ST_ERR:  st <= ST_ERR;

        default: st <= ST_ERR;
      endcase
    end
  end

endmodule
